// File: rtl/ram_loader.sv
// ram_loader: streams bytes from a valid/ready source into the processor's
// data RAM through its external write port at BASE_ADDR + n*STRIDE. Once
// NUM_WORDS bytes are loaded it pulses START_PROC and then waits for the
// processor to raise PROCESS_DONE.
// Optional feature macro: LOADER_CHECKSUM_EN adds a 16-bit modulo byte sum
// on CHECKSUM. Without the macro CHECKSUM is tied to zero.
module ram_loader #(
  parameter int          ADDR_W    = 16,
  parameter int          DATA_W    = 8,
  parameter int unsigned BASE_ADDR = 2,
  parameter int unsigned STRIDE    = 4,
  parameter int unsigned NUM_WORDS = 16384
) (
  input  logic              MAIN_CLOCK,
  input  logic              RESET,
  input  logic              LOAD_REQ,
  input  logic [DATA_W-1:0] IN_DATA,
  input  logic              IN_VALID,
  output logic              IN_READY,
  output logic [ADDR_W-1:0] ex_address,
  output logic [DATA_W-1:0] ex_datain,
  output logic              ex_wren,
  output logic              START_PROC,
  input  logic              PROCESS_DONE,
  output logic              LOADER_BUSY,
  output logic              RUN_DONE,
  output logic [ADDR_W-1:0] LOAD_COUNT,
  output logic              ADDR_WRAP,
  output logic [15:0]       CHECKSUM
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_START = 2'd2;
  localparam logic [1:0] S_RUN   = 2'd3;

  localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(STRIDE);
  localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(NUM_WORDS - 1);

  logic [1:0]        state;
  logic              load_req_d;
  logic              done_d;
  logic [ADDR_W-1:0] addr_p0;
  logic              vld_p0;
  logic              start_load;
  logic [ADDR_W:0]   step_p0;

  // Next write address with the overflow bit kept as the MSB.
  function automatic logic [ADDR_W:0] addr_step(input logic [ADDR_W-1:0] a);
    return {1'b0, a} + {1'b0, STRIDE_A};
  endfunction

  assign IN_READY    = (state == S_LOAD);
  assign START_PROC  = (state == S_START);
  assign LOADER_BUSY = (state != S_IDLE);
  assign vld_p0      = IN_VALID && IN_READY;
  assign start_load  = (state == S_IDLE) && LOAD_REQ && !load_req_d;
  assign step_p0     = addr_step(addr_p0);

  // Stage p0 -> p1: control FSM, edge detectors and the registered RAM write.
  always_ff @(posedge MAIN_CLOCK) begin
    if (RESET) begin
      state      <= S_IDLE;
      load_req_d <= 1'b0;
      done_d     <= 1'b0;
      addr_p0    <= '0;
      ex_address <= '0;
      ex_datain  <= '0;
      ex_wren    <= 1'b0;
      RUN_DONE   <= 1'b0;
      LOAD_COUNT <= '0;
      ADDR_WRAP  <= 1'b0;
    end else begin
      load_req_d <= LOAD_REQ;
      done_d     <= PROCESS_DONE;
      ex_wren    <= vld_p0;
      case (state)
        S_IDLE: begin
          if (start_load) begin
            state      <= S_LOAD;
            addr_p0    <= BASE_A;
            LOAD_COUNT <= '0;
            RUN_DONE   <= 1'b0;
            ADDR_WRAP  <= 1'b0;
          end
        end
        S_LOAD: begin
          if (vld_p0) begin
            ex_address <= addr_p0;
            ex_datain  <= IN_DATA;
            addr_p0    <= step_p0[ADDR_W-1:0];
            LOAD_COUNT <= LOAD_COUNT + ADDR_W'(1);
            if (step_p0[ADDR_W]) ADDR_WRAP <= 1'b1;
            if (LOAD_COUNT == LAST_CNT) state <= S_START;
          end
        end
        S_START: state <= S_RUN;
        default: begin
          // Only a fresh rising edge ends the run; a level left high from
          // the previous run is already captured in done_d.
          if (PROCESS_DONE && !done_d) begin
            state    <= S_IDLE;
            RUN_DONE <= 1'b1;
          end
        end
      endcase
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Stage p0 -> p1: running modulo-2^16 sum of accepted bytes.
  always_ff @(posedge MAIN_CLOCK) begin
    if (RESET) begin
      CHECKSUM <= '0;
    end else if (start_load) begin
      CHECKSUM <= '0;
    end else if (vld_p0) begin
      CHECKSUM <= CHECKSUM + 16'(IN_DATA);
    end
  end
`else
  assign CHECKSUM = '0;
`endif

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader: one instance with a short 4-byte load and
// one instance based near the top of the address space for the wrap case.
module tb_ram_loader;

  logic        MAIN_CLOCK = 1'b0;
  logic        RESET;
  logic        PROCESS_DONE;

  logic        a_load_req, a_in_valid, a_in_ready, a_ex_wren, a_start_proc;
  logic        a_busy, a_run_done, a_addr_wrap;
  logic [7:0]  a_in_data, a_ex_datain;
  logic [15:0] a_ex_address, a_load_count, a_checksum;

  logic        b_load_req, b_in_valid, b_in_ready, b_ex_wren, b_start_proc;
  logic        b_busy, b_run_done, b_addr_wrap;
  logic [7:0]  b_in_data, b_ex_datain;
  logic [15:0] b_ex_address, b_load_count, b_checksum;

  int n_cmp = 0;
  int n_err = 0;

  always #5 MAIN_CLOCK = ~MAIN_CLOCK;

  ram_loader #(.ADDR_W(16), .DATA_W(8), .BASE_ADDR(2), .STRIDE(4), .NUM_WORDS(4)) dut_a (
    .MAIN_CLOCK(MAIN_CLOCK), .RESET(RESET), .LOAD_REQ(a_load_req),
    .IN_DATA(a_in_data), .IN_VALID(a_in_valid), .IN_READY(a_in_ready),
    .ex_address(a_ex_address), .ex_datain(a_ex_datain), .ex_wren(a_ex_wren),
    .START_PROC(a_start_proc), .PROCESS_DONE(PROCESS_DONE), .LOADER_BUSY(a_busy),
    .RUN_DONE(a_run_done), .LOAD_COUNT(a_load_count), .ADDR_WRAP(a_addr_wrap),
    .CHECKSUM(a_checksum)
  );

  ram_loader #(.ADDR_W(16), .DATA_W(8), .BASE_ADDR(16'hFFFA), .STRIDE(4), .NUM_WORDS(3)) dut_b (
    .MAIN_CLOCK(MAIN_CLOCK), .RESET(RESET), .LOAD_REQ(b_load_req),
    .IN_DATA(b_in_data), .IN_VALID(b_in_valid), .IN_READY(b_in_ready),
    .ex_address(b_ex_address), .ex_datain(b_ex_datain), .ex_wren(b_ex_wren),
    .START_PROC(b_start_proc), .PROCESS_DONE(1'b0), .LOADER_BUSY(b_busy),
    .RUN_DONE(b_run_done), .LOAD_COUNT(b_load_count), .ADDR_WRAP(b_addr_wrap),
    .CHECKSUM(b_checksum)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge MAIN_CLOCK);
    #1;
  endtask

  initial begin
    int          vpat [7] = '{1, 0, 0, 1, 0, 1, 1};
    logic [15:0] b_addr [3] = '{16'hFFFA, 16'hFFFE, 16'h0002};
    logic [7:0]  a_bytes [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    int          k;

    RESET = 1'b1; PROCESS_DONE = 1'b0;
    a_load_req = 1'b0; a_in_valid = 1'b0; a_in_data = '0;
    b_load_req = 1'b0; b_in_valid = 1'b0; b_in_data = '0;
    tick(); tick();

    // Reset state
    check_val("rst_ready", 32'(a_in_ready), 0);
    check_val("rst_wren", 32'(a_ex_wren), 0);
    check_val("rst_addr", 32'(a_ex_address), 0);
    check_val("rst_count", 32'(a_load_count), 0);
    check_val("rst_busy", 32'(a_busy), 0);
    check_val("rst_start", 32'(a_start_proc), 0);
    check_val("rst_cksum", 32'(a_checksum), 0);
    RESET = 1'b0;
    tick();

    // 4-byte load with IN_VALID held high
    a_load_req = 1'b1;
    tick();
    check_val("t1_ready", 32'(a_in_ready), 1);
    a_load_req = 1'b0;
    a_in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_in_data = a_bytes[i];
      tick();
      check_val("t1_wren", 32'(a_ex_wren), 1);
      check_val("t1_addr", 32'(a_ex_address), 32'(2 + 4 * i));
      check_val("t1_data", 32'(a_ex_datain), 32'(a_bytes[i]));
      check_val("t1_start", 32'(a_start_proc), (i == 3) ? 1 : 0);
    end
    check_val("t1_count", 32'(a_load_count), 4);
    check_val("t1_ready_last", 32'(a_in_ready), 0);
    a_in_valid = 1'b0;
    tick();
    check_val("t1_run_wren", 32'(a_ex_wren), 0);
    check_val("t1_run_start", 32'(a_start_proc), 0);
    check_val("t1_run_busy", 32'(a_busy), 1);
    PROCESS_DONE = 1'b1;
    tick();
    check_val("t1_done", 32'(a_run_done), 1);
    check_val("t1_idle", 32'(a_busy), 0);

    // Gapped IN_VALID; PROCESS_DONE stays high from the previous run
    a_load_req = 1'b1;
    tick();
    check_val("t2_rundone_clr", 32'(a_run_done), 0);
    check_val("t2_ready", 32'(a_in_ready), 1);
    k = 0;
    for (int i = 0; i < 7; i++) begin
      a_in_valid = vpat[i][0];
      a_in_data  = 8'hA0 + 8'(i);
      tick();
      check_val("t2_wren", 32'(a_ex_wren), 32'(vpat[i]));
      if (vpat[i] != 0) begin
        check_val("t2_addr", 32'(a_ex_address), 32'(2 + 4 * k));
        check_val("t2_data", 32'(a_ex_datain), 32'(8'hA0 + 8'(i)));
        k++;
      end
    end
    check_val("t2_count", 32'(a_load_count), 4);
    check_val("t2_start", 32'(a_start_proc), 1);
    a_in_valid = 1'b0;
    tick(); tick(); tick();
    check_val("t3_hold_busy", 32'(a_busy), 1);
    check_val("t3_hold_done", 32'(a_run_done), 0);
    PROCESS_DONE = 1'b0;
    tick();
    check_val("t3_low_busy", 32'(a_busy), 1);
    PROCESS_DONE = 1'b1;
    tick();
    check_val("t3_busy", 32'(a_busy), 0);
    check_val("t3_done", 32'(a_run_done), 1);
    tick();
    check_val("t3_no_retrig", 32'(a_busy), 0);

    // Reset after the second beat, then restart
    a_load_req = 1'b0;
    tick();
    a_load_req = 1'b1;
    tick();
    a_in_valid = 1'b1;
    a_in_data = 8'h55;
    tick();
    a_in_data = 8'h66;
    tick();
    check_val("t4_count2", 32'(a_load_count), 2);
    RESET = 1'b1; a_load_req = 1'b0; a_in_valid = 1'b0;
    tick();
    check_val("t4_ready", 32'(a_in_ready), 0);
    check_val("t4_wren", 32'(a_ex_wren), 0);
    check_val("t4_count", 32'(a_load_count), 0);
    RESET = 1'b0;
    tick();
    a_load_req = 1'b1;
    tick();
    a_in_valid = 1'b1;
    a_in_data = 8'h77;
    tick();
    check_val("t4_re_addr", 32'(a_ex_address), 2);
    check_val("t4_re_data", 32'(a_ex_datain), 32'h77);
    check_val("t4_re_count", 32'(a_load_count), 1);
    a_in_valid = 1'b0;

    // Address wrap and checksum on the high-base instance
    b_load_req = 1'b1;
    tick();
    b_in_valid = 1'b1;
    b_in_data = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("t5_wren", 32'(b_ex_wren), 1);
      check_val("t5_addr", 32'(b_ex_address), 32'(b_addr[i]));
      if (i == 0) check_val("t5_nowrap", 32'(b_addr_wrap), 0);
    end
    check_val("t5_wrap", 32'(b_addr_wrap), 1);
    check_val("t5_start", 32'(b_start_proc), 1);
`ifdef LOADER_CHECKSUM_EN
    check_val("t6_cksum", 32'(b_checksum), 32'h02FD);
`else
    check_val("t6_cksum", 32'(b_checksum), 0);
`endif
    b_in_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
